spring_force_accumulator: RTL and testbench
===========================================

// Module: spring_force_accumulator
// PURPOSE
//  Receives the per-spring force stream from the springs engine (x/y force + valid strobe, one per spring, then done)
//  and folds it into net per-node force totals: +F on a spring's first node, -F on its second (equal and opposite).
//  Sits between the springs engine and the node integrator; presents a frame-stable net-force array with a 1-cycle valid.
// PARAMETERS
//  NUM_SPRINGS    2   springs per frame; k-th force pulse after start belongs to spring k
//  NUM_NODES      3   nodes in the body
//  FORCE_SIZE     5   width of incoming signed spring force components
//  ACCUM_SIZE     FORCE_SIZE+$clog2(NUM_SPRINGS)+2   width of signed per-node accumulators/outputs
// PORTS
//  clk_in               in   1                          system clock
//  rst_in               in   1                          synchronous, active-low reset (0 = reset)
//  start_in             in   1                          pulse: clear accumulators, begin frame (same pulse that starts the springs engine)
//  springs              in   [1:0][NUM_SPRINGS] x ($clog2(NUM_NODES)+1)   node index pairs; [0][s]=first, [1][s]=second
//  spring_force_x_in    in   FORCE_SIZE signed           x force on first node of current spring
//  spring_force_y_in    in   FORCE_SIZE signed           y force on first node of current spring
//  spring_force_valid_in in  1                          force components valid this cycle
//  springs_done_in      in   1                          springs engine finished frame
//  node_force_x_out     out  [NUM_NODES] x ACCUM_SIZE signed   net x force per node, stable between frames
//  node_force_y_out     out  [NUM_NODES] x ACCUM_SIZE signed   net y force per node
//  forces_valid_out     out  1                          1-cycle pulse: outputs updated
//  busy_out             out  1                          high in ACCUM and FINISH
//  overflow_out         out  1                          sticky per frame: some accumulator saturated
//  count_error_out      out  1                          sticky per frame: force count != NUM_SPRINGS, or node index >= NUM_NODES
// BEHAVIOUR
//  Reset (rst_in=0 at edge): state IDLE, all accumulators and outputs 0, all flags 0, spring counter 0.
//  FSM: IDLE --start_in--> ACCUM --springs_done_in--> FINISH --(1 cycle)--> IDLE.
//   start_in in any state (incl. ACCUM/FINISH): clear accumulators, counter, overflow/count_error; go ACCUM. Outputs keep last frame.
//  ACCUM: on spring_force_valid_in with counter s < NUM_SPRINGS: F=(x,y) sign-extended to ACCUM_SIZE;
//   acc[springs[0][s]] += F, acc[springs[1][s]] -= F in the same edge; counter++. Full throughput: valid may be high every cycle.
//   Negation performed after sign-extension (no overflow on most-negative input).
//   springs[0][s]==springs[1][s]: net zero, node unchanged. Index >= NUM_NODES: that endpoint skipped, count_error_out=1.
//   valid with s >= NUM_SPRINGS: force dropped, count_error_out=1.
//  Arithmetic: each add saturates to [-2^(ACCUM_SIZE-1), 2^(ACCUM_SIZE-1)-1]; on clamp overflow_out=1.
//  valid and springs_done_in same cycle: force applied, then state FINISH. Done with counter != NUM_SPRINGS: count_error_out=1.
//  FINISH edge: node_force_*_out <= acc; forces_valid_out=1 for exactly that following cycle; -> IDLE.
//   Latency: edge E samples done; edge E+1 updates outputs and raises valid; edge E+2 drops valid.
//  IDLE: spring_force_valid_in and springs_done_in ignored; start_in and valid same cycle -> start wins, force dropped.
//  Flags hold until next start_in or reset; reset mid-frame aborts, outputs cleared to 0.
// STRUCTURE
//  Shared package physics_pkg: POSITION/VELOCITY/FORCE/ACCUM size constants, node-index typedef, FSM state enum.
//  One sub-module: sat_add_signed #(W) (a, b -> saturated sum, clamp flag); two instances per axis (first-node add, second-node sub).
// TESTING (NUM_NODES=3, NUM_SPRINGS=2, FORCE_SIZE=5, springs (0,1),(1,2) unless stated)
//  Basic: start; forces (3,-2),(-1,4) on consecutive cycles; done -> node0=(3,-2), node1=(-4,6), node2=(1,-4), one valid pulse, flags 0.
//  Gapped + final-with-done: same forces with 3 idle cycles between, second valid together with done -> identical result, valid 2 edges after done.
//  Saturation: NUM_SPRINGS=3, ACCUM_SIZE=6, springs (0,1),(0,2),(0,1), x=15 each -> node0 x=31, node1 x=-30, node2 x=-15, overflow_out=1.
//  Count error: only one force then done -> node0=(3,-2), node1=(-3,2), node2=0, count_error_out=1; third extra pulse also flags error.
//  Restart mid-frame: start, one force, start again, two forces, done -> only second frame's totals appear; outputs unchanged until then.
//  Reset: drive rst_in=0 in ACCUM -> outputs 0, busy_out=0, no valid pulse; self-loop spring (1,1) contributes nothing.

Source files
------------

// File: rtl/spring_force_accumulator_pkg.sv
// Shared physics constants, node-index type and accumulator FSM states.
package spring_force_accumulator_pkg;

    localparam int unsigned POSITION_SIZE     = 16;
    localparam int unsigned VELOCITY_SIZE     = 12;
    localparam int unsigned FORCE_SIZE_DEF    = 5;
    localparam int unsigned NUM_SPRINGS_DEF   = 2;
    localparam int unsigned NUM_NODES_DEF     = 3;
    localparam int unsigned ACCUM_SIZE_DEF    = FORCE_SIZE_DEF + $clog2(NUM_SPRINGS_DEF) + 2;
    localparam int unsigned NODE_IDX_SIZE_DEF = $clog2(NUM_NODES_DEF) + 1;

    typedef logic [NODE_IDX_SIZE_DEF-1:0] node_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/spring_force_accumulator_sat_add.sv
// Signed W-bit adder that clamps to the representable range and flags the clamp.
module sat_add_signed #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         clamp
);

    logic [W:0] full;

    // One guard bit detects overflow; clamp toward the sign of the true result.
    always_comb begin
        full  = {a[W-1], a} + {b[W-1], b};
        clamp = full[W] ^ full[W-1];
        sum   = full[W-1:0];
        if (clamp) begin
            sum = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/spring_force_accumulator.sv
// Folds the per-spring force stream into saturated net per-node force totals.
module spring_force_accumulator
    import spring_force_accumulator_pkg::*;
#(
    parameter int unsigned NUM_SPRINGS = NUM_SPRINGS_DEF,
    parameter int unsigned NUM_NODES   = NUM_NODES_DEF,
    parameter int unsigned FORCE_SIZE  = FORCE_SIZE_DEF,
    parameter int unsigned ACCUM_SIZE  = FORCE_SIZE + $clog2(NUM_SPRINGS) + 2,
    localparam int unsigned IDX_W      = $clog2(NUM_NODES) + 1
) (
    input  logic                                         clk_in,
    input  logic                                         rst_in,
    input  logic                                         start_in,
    input  logic [1:0][NUM_SPRINGS-1:0][IDX_W-1:0]       springs,
    input  logic [FORCE_SIZE-1:0]                        spring_force_x_in,
    input  logic [FORCE_SIZE-1:0]                        spring_force_y_in,
    input  logic                                         spring_force_valid_in,
    input  logic                                         springs_done_in,
    output logic [NUM_NODES-1:0][ACCUM_SIZE-1:0]         node_force_x_out,
    output logic [NUM_NODES-1:0][ACCUM_SIZE-1:0]         node_force_y_out,
    output logic                                         forces_valid_out,
    output logic                                         busy_out,
    output logic                                         overflow_out,
    output logic                                         count_error_out
);

    localparam int unsigned CNT_W = $clog2(NUM_SPRINGS + 1);

    state_t                               state;
    logic [NUM_NODES-1:0][ACCUM_SIZE-1:0] acc_x;
    logic [NUM_NODES-1:0][ACCUM_SIZE-1:0] acc_y;
    logic [CNT_W-1:0]                     cnt;

    logic                         cnt_ok_c;
    logic                         take_c;
    logic [CNT_W-1:0]             cnt_next_c;
    logic [IDX_W-1:0]             first_c;
    logic [IDX_W-1:0]             second_c;
    logic                         first_ok_c;
    logic                         second_ok_c;
    logic                         apply_first_c;
    logic                         apply_second_c;
    logic signed [ACCUM_SIZE-1:0] fx_c;
    logic signed [ACCUM_SIZE-1:0] fy_c;
    logic signed [ACCUM_SIZE-1:0] nfx_c;
    logic signed [ACCUM_SIZE-1:0] nfy_c;
    logic [ACCUM_SIZE-1:0]        a_first_x_c;
    logic [ACCUM_SIZE-1:0]        a_first_y_c;
    logic [ACCUM_SIZE-1:0]        a_second_x_c;
    logic [ACCUM_SIZE-1:0]        a_second_y_c;
    logic [ACCUM_SIZE-1:0]        sum_first_x_c;
    logic [ACCUM_SIZE-1:0]        sum_first_y_c;
    logic [ACCUM_SIZE-1:0]        sum_second_x_c;
    logic [ACCUM_SIZE-1:0]        sum_second_y_c;
    logic                         clamp_first_x_c;
    logic                         clamp_first_y_c;
    logic                         clamp_second_x_c;
    logic                         clamp_second_y_c;
    logic                         ovf_c;
    logic                         cerr_c;

    // Select the current spring's endpoints and read their accumulators.
    always_comb begin
        first_c      = '0;
        second_c     = '0;
        a_first_x_c  = '0;
        a_first_y_c  = '0;
        a_second_x_c = '0;
        a_second_y_c = '0;
        cnt_ok_c     = (cnt < CNT_W'(NUM_SPRINGS));
        take_c       = spring_force_valid_in && cnt_ok_c;
        cnt_next_c   = cnt + CNT_W'(take_c);
        for (int s = 0; s < NUM_SPRINGS; s++) begin
            if (cnt == CNT_W'(s)) begin
                first_c  = springs[0][s];
                second_c = springs[1][s];
            end
        end
        first_ok_c     = (first_c  < IDX_W'(NUM_NODES));
        second_ok_c    = (second_c < IDX_W'(NUM_NODES));
        apply_first_c  = take_c && first_ok_c  && (first_c != second_c);
        apply_second_c = take_c && second_ok_c && (first_c != second_c);
        for (int n = 0; n < NUM_NODES; n++) begin
            if (first_c == IDX_W'(n)) begin
                a_first_x_c = acc_x[n];
                a_first_y_c = acc_y[n];
            end
            if (second_c == IDX_W'(n)) begin
                a_second_x_c = acc_x[n];
                a_second_y_c = acc_y[n];
            end
        end
        // Extend first so negating the most-negative force cannot wrap.
        fx_c  = ACCUM_SIZE'($signed(spring_force_x_in));
        fy_c  = ACCUM_SIZE'($signed(spring_force_y_in));
        nfx_c = -fx_c;
        nfy_c = -fy_c;
    end

    sat_add_signed #(.W(ACCUM_SIZE)) u_first_x (
        .a(a_first_x_c), .b(fx_c), .sum(sum_first_x_c), .clamp(clamp_first_x_c)
    );
    sat_add_signed #(.W(ACCUM_SIZE)) u_first_y (
        .a(a_first_y_c), .b(fy_c), .sum(sum_first_y_c), .clamp(clamp_first_y_c)
    );
    sat_add_signed #(.W(ACCUM_SIZE)) u_second_x (
        .a(a_second_x_c), .b(nfx_c), .sum(sum_second_x_c), .clamp(clamp_second_x_c)
    );
    sat_add_signed #(.W(ACCUM_SIZE)) u_second_y (
        .a(a_second_y_c), .b(nfy_c), .sum(sum_second_y_c), .clamp(clamp_second_y_c)
    );

    // Flag conditions raised by the current cycle while accumulating.
    always_comb begin
        ovf_c  = (apply_first_c  && (clamp_first_x_c  || clamp_first_y_c)) ||
                 (apply_second_c && (clamp_second_x_c || clamp_second_y_c));
        cerr_c = (spring_force_valid_in && (!cnt_ok_c || !first_ok_c || !second_ok_c)) ||
                 (springs_done_in && (cnt_next_c != CNT_W'(NUM_SPRINGS)));
    end

    // Frame FSM, accumulator update and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state            <= ST_IDLE;
            acc_x            <= '0;
            acc_y            <= '0;
            cnt              <= '0;
            node_force_x_out <= '0;
            node_force_y_out <= '0;
            forces_valid_out <= 1'b0;
            busy_out         <= 1'b0;
            overflow_out     <= 1'b0;
            count_error_out  <= 1'b0;
        end else begin
            forces_valid_out <= 1'b0;
            if (start_in) begin
                state           <= ST_ACCUM;
                acc_x           <= '0;
                acc_y           <= '0;
                cnt             <= '0;
                busy_out        <= 1'b1;
                overflow_out    <= 1'b0;
                count_error_out <= 1'b0;
            end else begin
                case (state)
                    ST_ACCUM: begin
                        cnt <= cnt_next_c;
                        for (int n = 0; n < NUM_NODES; n++) begin
                            if (apply_first_c && (first_c == IDX_W'(n))) begin
                                acc_x[n] <= sum_first_x_c;
                                acc_y[n] <= sum_first_y_c;
                            end
                            if (apply_second_c && (second_c == IDX_W'(n))) begin
                                acc_x[n] <= sum_second_x_c;
                                acc_y[n] <= sum_second_y_c;
                            end
                        end
                        if (ovf_c) begin
                            overflow_out <= 1'b1;
                        end
                        if (cerr_c) begin
                            count_error_out <= 1'b1;
                        end
                        if (springs_done_in) begin
                            state <= ST_FINISH;
                        end
                    end
                    ST_FINISH: begin
                        node_force_x_out <= acc_x;
                        node_force_y_out <= acc_y;
                        forces_valid_out <= 1'b1;
                        busy_out         <= 1'b0;
                        state            <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spring_force_accumulator.sv
// Directed bench: expected frame totals queued at stimulus time, popped on each valid pulse.
module tb_spring_force_accumulator;

    localparam int unsigned AW     = 8;
    localparam int unsigned AW_SAT = 6;

    typedef struct {
        int   x0, x1, x2, y0, y1, y2;
        logic ovf, cerr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, start, valid, done;
    logic [4:0]           fx, fy;
    logic [1:0][1:0][2:0] springs_a;
    logic [1:0][2:0][2:0] springs_b;

    logic [2:0][AW-1:0]     nx, ny;
    logic                   valid_o, busy, ovf, cerr;
    logic [2:0][AW_SAT-1:0] sx, sy;
    logic                   s_valid, s_busy, s_ovf, s_cerr;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    spring_force_accumulator dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .springs(springs_a),
        .spring_force_x_in(fx), .spring_force_y_in(fy),
        .spring_force_valid_in(valid), .springs_done_in(done),
        .node_force_x_out(nx), .node_force_y_out(ny),
        .forces_valid_out(valid_o), .busy_out(busy),
        .overflow_out(ovf), .count_error_out(cerr)
    );

    spring_force_accumulator #(.NUM_SPRINGS(3), .NUM_NODES(3), .FORCE_SIZE(5), .ACCUM_SIZE(AW_SAT)) dut_sat (
        .clk_in(clk), .rst_in(rst), .start_in(start), .springs(springs_b),
        .spring_force_x_in(fx), .spring_force_y_in(fy),
        .spring_force_valid_in(valid), .springs_done_in(done),
        .node_force_x_out(sx), .node_force_y_out(sy),
        .forces_valid_out(s_valid), .busy_out(s_busy),
        .overflow_out(s_ovf), .count_error_out(s_cerr)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic frame_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int x, input int y);
        valid = 1'b1;
        fx    = 5'(x);
        fy    = 5'(y);
        tick();
        valid = 1'b0;
    endtask

    task automatic finish_frame();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic push(input int x0, input int x1, input int x2,
                        input int y0, input int y1, input int y2,
                        input logic o, input logic c);
        exp_t e;
        e.x0 = x0; e.x1 = x1; e.x2 = x2;
        e.y0 = y0; e.y1 = y1; e.y2 = y2;
        e.ovf = o; e.cerr = c;
        sb.push_back(e);
    endtask

    task automatic wait_and_compare(input string tag, input int max_cycles);
        bit   found = 1'b0;
        exp_t e;
        for (int i = 0; i < max_cycles && !found; i++) begin
            tick();
            if (valid_o === 1'b1) found = 1'b1;
        end
        chk({tag, "_valid_seen"}, found, 1);
        if (found) begin
            if (sb.size() == 0) begin
                chk({tag, "_scoreboard_empty"}, 0, 1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_n0x"}, $signed(nx[0]), e.x0);
                chk({tag, "_n1x"}, $signed(nx[1]), e.x1);
                chk({tag, "_n2x"}, $signed(nx[2]), e.x2);
                chk({tag, "_n0y"}, $signed(ny[0]), e.y0);
                chk({tag, "_n1y"}, $signed(ny[1]), e.y1);
                chk({tag, "_n2y"}, $signed(ny[2]), e.y2);
                chk({tag, "_ovf"}, ovf, e.ovf);
                chk({tag, "_cerr"}, cerr, e.cerr);
            end
            tick();
            chk({tag, "_pulse_end"}, valid_o, 0);
            chk({tag, "_idle"}, busy, 0);
        end
    endtask

    initial begin
        bit sat_found;
        rst = 1'b0; start = 1'b0; valid = 1'b0; done = 1'b0;
        fx = '0; fy = '0;
        springs_a[0][0] = 3'd0; springs_a[1][0] = 3'd1;
        springs_a[0][1] = 3'd1; springs_a[1][1] = 3'd2;
        springs_b[0][0] = 3'd0; springs_b[1][0] = 3'd1;
        springs_b[0][1] = 3'd0; springs_b[1][1] = 3'd2;
        springs_b[0][2] = 3'd0; springs_b[1][2] = 3'd1;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        chk("reset_n0x", $signed(nx[0]), 0);
        chk("reset_busy", busy, 0);
        chk("reset_valid", valid_o, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_cerr", cerr, 0);

        // Basic frame with exact latency check
        frame_start();
        chk("basic_busy", busy, 1);
        send(3, -2);
        send(-1, 4);
        push(3, -4, 1, -2, 6, -4, 1'b0, 1'b0);
        finish_frame();
        chk("basic_latency_valid_low", valid_o, 0);
        chk("basic_latency_busy", busy, 1);
        wait_and_compare("basic", 1);

        // Gapped forces, last force together with done
        frame_start();
        send(3, -2);
        repeat (3) tick();
        valid = 1'b1; fx = 5'(-1); fy = 5'(4); done = 1'b1;
        push(3, -4, 1, -2, 6, -4, 1'b0, 1'b0);
        tick();
        valid = 1'b0; done = 1'b0;
        chk("gapped_latency_valid_low", valid_o, 0);
        wait_and_compare("gapped", 1);

        // Too few forces
        frame_start();
        send(3, -2);
        push(3, -3, 0, -2, 2, 0, 1'b0, 1'b1);
        finish_frame();
        wait_and_compare("short", 3);

        // Extra third force is dropped but flagged
        frame_start();
        send(3, -2);
        send(-1, 4);
        send(5, 5);
        push(3, -4, 1, -2, 6, -4, 1'b0, 1'b1);
        finish_frame();
        wait_and_compare("extra", 3);

        // Restart mid-frame; start with valid drops the force
        frame_start();
        send(3, -2);
        chk("restart_hold_n1x", $signed(nx[1]), -4);
        start = 1'b1; valid = 1'b1; fx = 5'(9); fy = 5'(9);
        tick();
        start = 1'b0; valid = 1'b0;
        send(2, 1);
        send(1, 1);
        push(2, -1, -1, 1, 0, -1, 1'b0, 1'b0);
        finish_frame();
        wait_and_compare("restart", 3);

        // Saturation on the 3-spring, 6-bit instance
        frame_start();
        send(15, 0);
        send(15, 0);
        send(15, 0);
        finish_frame();
        sat_found = 1'b0;
        for (int i = 0; i < 4 && !sat_found; i++) begin
            if (s_valid === 1'b1) sat_found = 1'b1;
            else tick();
        end
        chk("sat_valid_seen", sat_found, 1);
        chk("sat_n0x", $signed(sx[0]), 31);
        chk("sat_n1x", $signed(sx[1]), -30);
        chk("sat_n2x", $signed(sx[2]), -15);
        chk("sat_n0y", $signed(sy[0]), 0);
        chk("sat_ovf", s_ovf, 1);
        chk("sat_cerr", s_cerr, 0);
        repeat (2) tick();

        // Reset mid-frame clears outputs without a valid pulse
        frame_start();
        send(3, -2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midreset_n1x", $signed(nx[1]), 0);
        chk("midreset_n0y", $signed(ny[0]), 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_valid", valid_o, 0);

        // Idle ignores valid and done
        valid = 1'b1; done = 1'b1; fx = 5'(4); fy = 5'(4);
        repeat (2) tick();
        valid = 1'b0; done = 1'b0;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_valid", valid_o, 0);
        chk("idle_n2x", $signed(nx[2]), 0);

        // Self-loop spring contributes nothing
        springs_a[0][0] = 3'd1; springs_a[1][0] = 3'd1;
        frame_start();
        send(7, -3);
        send(2, 2);
        push(0, 2, -2, 0, 2, -2, 1'b0, 1'b0);
        finish_frame();
        wait_and_compare("selfloop", 3);

        // Out-of-range endpoint skipped; most-negative force negated cleanly
        springs_a[0][0] = 3'd0; springs_a[1][0] = 3'd1;
        springs_a[0][1] = 3'd4; springs_a[1][1] = 3'd2;
        frame_start();
        send(1, 1);
        send(-16, -16);
        push(1, -1, 16, 1, -1, 16, 1'b0, 1'b1);
        finish_frame();
        wait_and_compare("badindex", 3);

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
